// File: rtl/queue_2x412_pkg.sv
// Shared types and helpers for the 2x412 pipeline queue.
package queue_2x412_pkg;

    localparam int DEFAULT_DEPTH = 2;
    localparam int DEFAULT_WIDTH = 412;

    typedef logic [DEFAULT_WIDTH-1:0] payload_t;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic int unsigned ptr_next(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ram_2x412.sv
// 1R1W storage array: posedge write, combinational read.
module ram_2x412
    import queue_2x412_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    R0_addr,
    input  logic             R0_en,
    input  logic             R0_clk,
    output logic [WIDTH-1:0] R0_data,
    input  logic [AW-1:0]    W0_addr,
    input  logic             W0_en,
    input  logic             W0_clk,
    input  logic [WIDTH-1:0] W0_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Reads are asynchronous; the read clock exists only for port parity.
    logic unused_r0_clk;
    assign unused_r0_clk = R0_clk;

    always_ff @(posedge W0_clk) begin
        if (W0_en) begin
            mem[W0_addr] <= W0_data;
        end
    end

    assign R0_data = R0_en ? mem[R0_addr] : {WIDTH{1'bx}};

endmodule

// File: rtl/queue_2x412.sv
// Valid/ready FIFO controller driving an external 1R1W array.
module queue_2x412
    import queue_2x412_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PIPE  = 0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    output logic             io_enq_ready,
    input  logic             io_enq_valid,
    input  logic [WIDTH-1:0] io_enq_bits,
    input  logic             io_deq_ready,
    output logic             io_deq_valid,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic [CW-1:0]    io_count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] enq_ptr;
    logic [PW-1:0] deq_ptr;
    logic          maybe_full;

    logic ptr_match;
    logic empty;
    logic full;
    logic do_enq;
    logic do_deq;

    logic [CW-1:0]    diff;
    logic [WIDTH-1:0] r0_data;

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;

    assign io_deq_valid = ~empty;
    assign io_enq_ready = (PIPE != 0) ? (~full | io_deq_ready) : ~full;

    assign do_enq = io_enq_valid & io_enq_ready;
    assign do_deq = io_deq_valid & io_deq_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) begin
                enq_ptr <= PW'(ptr_next(32'(enq_ptr), DEPTH));
            end
            if (do_deq) begin
                deq_ptr <= PW'(ptr_next(32'(deq_ptr), DEPTH));
            end
            if (do_enq != do_deq) begin
                maybe_full <= do_enq;
            end
        end
    end

    // Modular difference; adding DEPTH on underflow keeps it in [0, DEPTH).
    assign diff = CW'(enq_ptr) - CW'(deq_ptr)
                + ((deq_ptr > enq_ptr) ? CW'(DEPTH) : CW'(0));
    assign io_count = full ? CW'(DEPTH) : diff;

    ram_2x412 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .R0_addr (deq_ptr),
        .R0_en   (1'b1),
        .R0_clk  (clock),
        .R0_data (r0_data),
        .W0_addr (enq_ptr),
        .W0_en   (do_enq & ~reset),
        .W0_clk  (clock),
        .W0_data (io_enq_bits)
    );

    assign io_deq_bits = r0_data;

endmodule

// File: tb/tb_queue_2x412.sv
// Directed and random scoreboard bench for queue_2x412.
module tb_queue_2x412;
    import queue_2x412_pkg::*;

    logic     clock = 1'b0;
    logic     reset;
    always #5 clock = ~clock;

    logic     enq_ready, enq_valid, deq_ready, deq_valid;
    payload_t enq_bits, deq_bits;
    logic [1:0] count;

    logic     p_enq_ready, p_enq_valid, p_deq_ready, p_deq_valid;
    payload_t p_enq_bits, p_deq_bits;
    logic [1:0] p_count;

    payload_t sb[$];
    int mcount;
    int checks;
    int errors;

    queue_2x412 #(.PIPE(0)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .io_enq_ready (enq_ready),
        .io_enq_valid (enq_valid),
        .io_enq_bits  (enq_bits),
        .io_deq_ready (deq_ready),
        .io_deq_valid (deq_valid),
        .io_deq_bits  (deq_bits),
        .io_count     (count)
    );

    queue_2x412 #(.PIPE(1)) dut1 (
        .clock        (clock),
        .reset        (reset),
        .io_enq_ready (p_enq_ready),
        .io_enq_valid (p_enq_valid),
        .io_enq_bits  (p_enq_bits),
        .io_deq_ready (p_deq_ready),
        .io_deq_valid (p_deq_valid),
        .io_deq_bits  (p_deq_bits),
        .io_count     (p_count)
    );

    task automatic chk(input string tag, input payload_t obs,
                       input payload_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic payload_t rnd();
        payload_t p;
        for (int i = 0; i < 12; i++) p[i*32 +: 32] = $urandom;
        p[411:384] = 28'($urandom);
        return p;
    endfunction

    // One cycle on the PIPE=0 queue against the reference model.
    task automatic cyc(input logic ev, input payload_t eb, input logic dr);
        logic m_enq, m_deq;
        enq_valid = ev;
        enq_bits  = eb;
        deq_ready = dr;
        #1;
        chk("enq_ready", payload_t'(enq_ready), payload_t'(mcount < 2 ? 1 : 0));
        chk("deq_valid", payload_t'(deq_valid), payload_t'(mcount > 0 ? 1 : 0));
        chk("count", payload_t'(count), payload_t'(mcount));
        m_deq = (mcount > 0) && dr;
        m_enq = ev && (mcount < 2);
        if (m_deq) chk("deq_bits", deq_bits, sb.pop_front());
        if (m_enq) sb.push_back(eb);
        mcount = mcount + int'(m_enq) - int'(m_deq);
        @(posedge clock);
        #1;
    endtask

    initial begin
        payload_t a, b, v;
        checks = 0;
        errors = 0;
        mcount = 0;
        reset = 1'b1;
        enq_valid = 0; enq_bits = '0; deq_ready = 0;
        p_enq_valid = 0; p_enq_bits = '0; p_deq_ready = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // idle after reset
        repeat (3) cyc(1'b0, '0, 1'b0);

        // fill with A then B, then drain
        a = payload_t'(1);
        b = '1;
        cyc(1'b1, a, 1'b0);
        cyc(1'b1, b, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);

        // full, PIPE=0: enqueue stalls while dequeue proceeds
        cyc(1'b1, payload_t'(32'hA1), 1'b0);
        cyc(1'b1, payload_t'(32'hA2), 1'b0);
        cyc(1'b1, payload_t'(32'hA3), 1'b1);
        cyc(1'b1, payload_t'(32'hA4), 1'b1);
        repeat (3) cyc(1'b0, '0, 1'b1);

        // streaming with wrap
        for (int i = 0; i < 101; i++) cyc(1'b1, payload_t'(i + 1000), 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1);

        // PIPE=1: full queue accepts while dequeuing
        enq_valid = 0; deq_ready = 0;
        p_enq_valid = 1; p_enq_bits = payload_t'(32'h11); p_deq_ready = 0;
        @(posedge clock); #1;
        p_enq_bits = payload_t'(32'h22);
        @(posedge clock); #1;
        p_enq_bits = payload_t'(32'h33);
        #1;
        chk("p_count_full", payload_t'(p_count), payload_t'(2));
        chk("p_enq_ready_stall", payload_t'(p_enq_ready), payload_t'(0));
        p_deq_ready = 1;
        #1;
        chk("p_enq_ready_pipe", payload_t'(p_enq_ready), payload_t'(1));
        chk("p_head0", p_deq_bits, payload_t'(32'h11));
        @(posedge clock); #1;
        p_enq_valid = 0;
        #1;
        chk("p_count_hold", payload_t'(p_count), payload_t'(2));
        chk("p_head1", p_deq_bits, payload_t'(32'h22));
        @(posedge clock); #1;
        chk("p_count_1", payload_t'(p_count), payload_t'(1));
        chk("p_head2", p_deq_bits, payload_t'(32'h33));
        @(posedge clock); #1;
        chk("p_count_0", payload_t'(p_count), payload_t'(0));
        chk("p_deq_valid_0", payload_t'(p_deq_valid), payload_t'(0));
        p_deq_ready = 0;

        // asynchronous reset mid-cycle with two entries held
        cyc(1'b1, payload_t'(32'hC1), 1'b0);
        cyc(1'b1, payload_t'(32'hC2), 1'b0);
        enq_valid = 0;
        #1;
        chk("pre_rst_count", payload_t'(count), payload_t'(2));
        #1;
        reset = 1'b1;
        #1;
        chk("rst_deq_valid", payload_t'(deq_valid), payload_t'(0));
        chk("rst_count", payload_t'(count), payload_t'(0));
        chk("rst_enq_ready", payload_t'(enq_ready), payload_t'(1));
        sb.delete();
        mcount = 0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, payload_t'(32'hD1), 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);

        // random traffic, 30% stall on both sides
        for (int i = 0; i < 10000; i++) begin
            v = rnd();
            cyc($urandom_range(0, 99) >= 30, v, $urandom_range(0, 99) >= 30);
        end
        while (mcount > 0) cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
